// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    // Rounded clocks per oversample tick
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// Output reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == LW'(DEPTH));
    assign level = cnt_q;
    assign dout  = empty ? '0 : mem_q[rd_q];

    // A pop frees the slot a same-cycle push needs when full
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a receive FIFO.
// Sticky overrun and framing flags; set beats clear.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk_clk,
    input  logic                              reset_reset,
    input  logic                              uart_rxd,
    output logic [7:0]                        rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overrun,
    output logic                              framing_err,
    input  logic                              clear_err
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic            sync1_q, sync2_q;
    logic            rxd;
    logic [DW-1:0]   div_q, div_d;
    logic            tick;
    rx_state_e       state_q;
    logic [3:0]      os_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            stop_sample;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            ovr_q, ovr_d;
    logic            fe_q, fe_d;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rxd = sync2_q;

    always_comb begin
        div_d = '0;
        tick  = 1'b0;
        if (state_q != IDLE) begin
            tick  = (div_q == DW'(DIV - 1));
            div_d = tick ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) div_q <= '0;
        else             div_q <= div_d;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd) begin
                        state_q <= START;
                        os_q    <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_q == 4'(MID_SAMPLE)) begin
                            os_q    <= '0;
                            bit_q   <= '0;
                            state_q <= rxd ? IDLE : DATA;
                        end else begin
                            os_q <= os_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        os_q <= os_q + 4'd1;
                        if (os_q == 4'(OVERSAMPLE - 1)) begin
                            shift_q <= {rxd, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'(DATA_BITS - 1)) state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        os_q <= os_q + 4'd1;
                        if (os_q == 4'(OVERSAMPLE - 1)) begin
                            state_q <= rxd ? IDLE : WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxd) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state_q == STOP) & tick
                       & (os_q == 4'(OVERSAMPLE - 1));
    assign push = stop_sample & rxd;
    assign pop  = ~fifo_empty & rx_ready;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_comb begin
        ovr_d = (ovr_q & ~clear_err) | (push & fifo_full & ~pop);
        fe_d  = (fe_q & ~clear_err) | (stop_sample & ~rxd);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            fe_q  <= fe_d;
        end
    end

    assign rx_valid    = ~fifo_empty;
    assign overrun     = ovr_q;
    assign framing_err = fe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed table, corner sequences,
// and random frames against a queue-based reference.
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 781_250;
    localparam int DEPTH  = 16;
    localparam int DIV    = 4;
    localparam int BIT    = 16 * DIV;
    localparam int LW     = $clog2(DEPTH + 1);
    // posedges from start-edge drive to the stop-sample edge
    localparam int STOP_EDGE = 3 + DIV * (8 + 16 * 9);

    logic          clk;
    logic          rst;
    logic          rxd;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [LW-1:0] fifo_level;
    logic          overrun;
    logic          framing_err;
    logic          clear_err;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         lvl;
        logic       ovr;
        logic       fe;
    } vec_t;

    vec_t       tbl [3];
    logic [7:0] mq [$];
    logic       m_ovr;
    logic       m_fe;
    logic [7:0] d;
    logic       ok;
    int         n_chk;
    int         n_fail;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .uart_rxd    (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .framing_err (framing_err),
        .clear_err   (clear_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(b[i], BIT);
        if (good) begin
            line(1'b1, BIT);
        end else begin
            line(1'b0, 2 * BIT);
            line(1'b1, BIT);
        end
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        chk({nm, "_valid"}, 32'(rx_valid), 1);
        chk({nm, "_data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_valid"}, 32'(rx_valid), 0);
        chk({nm, "_level"}, 32'(fifo_level), 0);
        chk({nm, "_ovr"}, 32'(overrun), 0);
        chk({nm, "_fe"}, 32'(framing_err), 0);
        chk({nm, "_data"}, 32'(rx_data), 0);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_level"}, 32'(fifo_level), mq.size());
        chk({nm, "_ovr"}, 32'(overrun), 32'(m_ovr));
        chk({nm, "_fe"}, 32'(framing_err), 32'(m_fe));
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rxd       = 1'b1;
        rx_ready  = 1'b0;
        clear_err = 1'b0;
        rst       = 1'b0;
        m_ovr     = 1'b0;
        m_fe      = 1'b0;

        tbl[0] = '{8'h5A, 1'b1, 1, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 1, 1'b0, 1'b1};
        tbl[2] = '{8'h3C, 1'b1, 2, 1'b0, 1'b1};

        @(negedge clk);
        do_reset();
        chk_reset_vals("rst");

        for (int i = 0; i < 3; i++) begin
            send_frame(tbl[i].data, tbl[i].stop_ok);
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), tbl[i].lvl);
            chk($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'(tbl[i].ovr));
            chk($sformatf("tbl%0d_fe", i), 32'(framing_err), 32'(tbl[i].fe));
        end
        pop_expect("tbl_pop0", 8'h5A);
        pop_expect("tbl_pop1", 8'h3C);
        chk("tbl_empty", 32'(rx_valid), 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_fe", 32'(framing_err), 0);

        line(1'b0, 4 * DIV);
        line(1'b1, 2 * BIT);
        chk("glitch_level", 32'(fifo_level), 0);
        chk("glitch_fe", 32'(framing_err), 0);
        send_frame(8'h81, 1'b1);
        chk("post_glitch_level", 32'(fifo_level), 1);
        pop_expect("post_glitch", 8'h81);

        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        send_frame(8'hFF, 1'b1);
        chk("burst_level", 32'(fifo_level), 16);
        chk("burst_ovr", 32'(overrun), 1);
        for (int i = 0; i < 16; i++)
            pop_expect($sformatf("burst_pop%0d", i), 8'(i));
        chk("burst_empty", 32'(rx_valid), 0);
        chk("burst_ovr_sticky", 32'(overrun), 1);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("pre_rst_level", 32'(fifo_level), 2);
        d = 8'h96;
        line(1'b0, BIT);
        for (int i = 0; i < 4; i++) line(d[i], BIT);
        line(d[4], BIT / 2);
        rxd = 1'b1;
        do_reset();
        chk_reset_vals("midrst");
        line(1'b1, BIT);
        chk("midrst_idle_level", 32'(fifo_level), 0);
        send_frame(8'hC3, 1'b1);
        chk("midrst_c3_level", 32'(fifo_level), 1);
        pop_expect("midrst_c3", 8'hC3);

        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1);
        chk("full_level", 32'(fifo_level), 16);
        chk("full_ovr", 32'(overrun), 0);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                chk("pp_pre_level", 32'(fifo_level), 16);
                chk("pp_pre_data", 32'(rx_data), 32'h40);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                chk("pp_level", 32'(fifo_level), 16);
                chk("pp_ovr", 32'(overrun), 0);
            end
        join
        for (int i = 1; i < 16; i++)
            pop_expect($sformatf("pp_pop%0d", i), 8'h40 + 8'(i));
        pop_expect("pp_last", 8'h77);
        chk("pp_empty", 32'(rx_valid), 0);

        for (int i = 0; i < 30; i++) begin
            line(1'b1, $urandom_range(0, 2) * BIT);
            d  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(d, ok);
            if (!ok)                   m_fe = 1'b1;
            else if (mq.size() < DEPTH) mq.push_back(d);
            else                       m_ovr = 1'b1;
            chk_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 5) == 0) begin
                clear_err = 1'b1;
                @(negedge clk);
                clear_err = 1'b0;
                m_ovr = 1'b0;
                m_fe  = 1'b0;
                chk_model($sformatf("rnd%0d_clr", i));
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int k = $urandom_range(1, 3); k > 0 && mq.size() > 0; k--) begin
                    pop_expect($sformatf("rnd%0d_pop", i), mq[0]);
                    void'(mq.pop_front());
                end
            end
        end
        while (mq.size() > 0) begin
            pop_expect("final_pop", mq[0]);
            void'(mq.pop_front());
        end
        chk("final_empty", 32'(rx_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
